trig_gate: RTL and testbench
============================

// Module: trig_gate
// PURPOSE
//  Consumes the debounced level/tick pair from the digital-input debouncer.
//  Turns each confirmed rising event into a timed trigger window for the lock
//  sequencer (ramp/lock start), with programmable width, retrigger and holdoff.
//  Counts accepted and rejected events for the register bank.
// PARAMETERS
//  W  16  width of width_i/holdoff_i cycle counts (8 ns/cycle)
//  C  16  width of event_cnt_o/missed_cnt_o (saturating)
// PORTS
//  clk           in   1  system clock, all logic on posedge
//  rstn          in   1  synchronous active-low reset
//  db_level_i    in   1  debounced level (from debounce db_level)
//  db_tick_i     in   1  one-cycle confirmed-rise pulse (from debounce db_tick)
//  enable_i      in   1  block enable; 0 aborts and ignores inputs
//  retrig_i      in   1  1: tick during ACTIVE reloads window
//  gate_i        in   1  1: ACTIVE also held while db_level_i=1
//  width_i       in   W  trigger window length in cycles (0 treated as 1)
//  holdoff_i     in   W  dead time after window, in cycles (0 = none)
//  clear_i       in   1  synchronous clear of both counters
//  trig_o        out  1  registered trigger window
//  busy_o        out  1  state != IDLE
//  event_cnt_o   out  C  accepted events
//  missed_cnt_o  out  C  ticks rejected (ACTIVE w/o retrig, or HOLDOFF)
// BEHAVIOUR
//  One clock; reset is synchronous and active-low (rstn sampled on posedge clk).
//  Reset: state=IDLE, trig_o=0, busy_o=0, both counters 0, down-counter 0.
//  States: IDLE, ACTIVE, HOLDOFF; 2-bit register; undefined codes -> IDLE.
//  Internal down-counter cnt[W-1:0]; wl = (width_i==0) ? 1 : width_i.
//  IDLE: tick & enable -> ACTIVE, cnt=wl-1, event_cnt++.
//  ACTIVE: trig_o=1.
//   - tick & retrig_i: cnt=wl-1, event_cnt++.
//   - tick & !retrig_i: missed_cnt++, no reload.
//   - cnt!=0: cnt--.
//   - cnt==0 & gate_i & db_level_i: stay ACTIVE, cnt held at 0.
//   - cnt==0 otherwise: holdoff_i!=0 -> HOLDOFF, cnt=holdoff_i-1; else IDLE.
//   - Reload by retrigger takes priority over the cnt==0 exit.
//  HOLDOFF: trig_o=0; tick -> missed_cnt++; cnt!=0 -> cnt--; cnt==0 -> IDLE.
//  Latency: tick at cycle n -> trig_o=1 on cycles n+1..n+wl (no retrig/gate).
//  Back-to-back, holdoff=0: IDLE is entered at n+wl+1 and a tick there is
//   accepted -> minimum 1-cycle low gap on trig_o.
//  width_i/holdoff_i are sampled only at load; changes mid-window have no effect.
//  enable_i=0: next state IDLE, trig_o=0 next cycle, cnt=0; ticks neither
//   accepted nor counted as missed; counters retain value.
//  Counters saturate at 2^C-1 (no wrap).
//  clear_i has priority over increment in the same cycle -> result 0.
//   The state transition still happens.
//  trig_o/busy_o are registered outputs, derived from next-state (no glitches).
//  db_level_i is used only in gate mode; no event is generated from it alone.
// TESTING
//  T1 width=4, holdoff=0, tick @10 -> trig_o=1 cycles 11..14, event_cnt=1, busy
//     falls @15.
//  T2 width=0, tick -> exactly 1-cycle trig_o; width=3, holdoff=5, ticks @10,12,16
//     -> trig 11..13, event_cnt=1, missed_cnt=2; tick @19 accepted.
//  T3 retrig=1, width=4, ticks @10,12 -> trig 11..16 continuous, event_cnt=2,
//     missed=0; gate=1 with db_level high to @30 -> trig held to 30, drops @31.
//  T4 enable drop @12 during T1 window -> trig_o=0 @13, state IDLE; tick @14 with
//     enable=0 -> no change to any counter.
//  T5 C=4: 17 accepted ticks -> event_cnt=15; clear_i with tick same cycle ->
//     event_cnt=0 next, trig_o still starts.
//  T6 rstn=0 mid-ACTIVE -> next cycle all outputs 0, state IDLE; random
//     tick/enable soak vs reference model.

Source files
------------

// File: rtl/trig_gate.sv
// trig_gate: turns debounced rising events into timed trigger windows with
// programmable width, retrigger, gate-hold and holdoff, plus event counters.
module trig_gate #(
   parameter int W = 16,
   parameter int C = 16
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         db_level_i,
   input  logic         db_tick_i,
   input  logic         enable_i,
   input  logic         retrig_i,
   input  logic         gate_i,
   input  logic [W-1:0] width_i,
   input  logic [W-1:0] holdoff_i,
   input  logic         clear_i,
   output logic         trig_o,
   output logic         busy_o,
   output logic [C-1:0] event_cnt_o,
   output logic [C-1:0] missed_cnt_o
);
   typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, HOLDOFF = 2'd2} state_t;
   state_t       state_q, state_d;
   logic [W-1:0] cnt_q, cnt_d;
   logic         trig_q, trig_d, busy_q, busy_d;
   logic [C-1:0] ev_q, ev_d, miss_q, miss_d;
   logic         ev_inc, miss_inc;
   logic [W-1:0] wl_m1, ho_m1;
   assign wl_m1 = (width_i == '0) ? '0 : width_i - W'(1);
   assign ho_m1 = holdoff_i - W'(1);
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         trig_q  <= 1'b0;
         busy_q  <= 1'b0;
         ev_q    <= '0;
         miss_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         trig_q  <= trig_d;
         busy_q  <= busy_d;
         ev_q    <= ev_d;
         miss_q  <= miss_d;
      end
   end
   // Retrigger reload is checked before the cnt==0 exit so it wins.
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      ev_inc   = 1'b0;
      miss_inc = 1'b0;
      if (!enable_i) begin
         state_d = IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            IDLE: if (db_tick_i) begin
               state_d = ACTIVE;
               cnt_d   = wl_m1;
               ev_inc  = 1'b1;
            end
            ACTIVE: if (db_tick_i && retrig_i) begin
               cnt_d  = wl_m1;
               ev_inc = 1'b1;
            end else begin
               miss_inc = db_tick_i;
               if (cnt_q != '0) cnt_d = cnt_q - W'(1);
               else if (gate_i && db_level_i) cnt_d = '0;
               else if (holdoff_i != '0) begin
                  state_d = HOLDOFF;
                  cnt_d   = ho_m1;
               end else state_d = IDLE;
            end
            HOLDOFF: begin
               miss_inc = db_tick_i;
               if (cnt_q != '0) cnt_d = cnt_q - W'(1);
               else state_d = IDLE;
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
            end
         endcase
      end
   end
   always_comb begin
      trig_d = (state_d == ACTIVE);
      busy_d = (state_d != IDLE);
      ev_d   = clear_i ? '0 : (ev_inc && ev_q != '1) ? ev_q + C'(1) : ev_q;
      miss_d = clear_i ? '0 : (miss_inc && miss_q != '1) ? miss_q + C'(1) : miss_q;
   end
   assign trig_o       = trig_q;
   assign busy_o       = busy_q;
   assign event_cnt_o  = ev_q;
   assign missed_cnt_o = miss_q;
endmodule

// File: tb/tb_trig_gate.sv
// tb_trig_gate: directed vector table for trig_gate (C=4) followed by a
// randomized soak against a cycle-level reference model.
module tb_trig_gate;
   logic        clk = 1'b0;
   logic        rstn, db_level_i, db_tick_i, enable_i, retrig_i, gate_i, clear_i;
   logic [15:0] width_i, holdoff_i;
   logic        trig_o, busy_o;
   logic [3:0]  event_cnt_o, missed_cnt_o;
   int          checks = 0;
   int          passed = 0;
   always #5 clk = ~clk;
   trig_gate #(.W(16), .C(4)) dut (
      .clk(clk), .rstn(rstn), .db_level_i(db_level_i), .db_tick_i(db_tick_i),
      .enable_i(enable_i), .retrig_i(retrig_i), .gate_i(gate_i),
      .width_i(width_i), .holdoff_i(holdoff_i), .clear_i(clear_i),
      .trig_o(trig_o), .busy_o(busy_o), .event_cnt_o(event_cnt_o),
      .missed_cnt_o(missed_cnt_o)
   );
   typedef struct {
      string       name;
      logic        rstn, en, tick, lvl, retrig, gate, clr;
      logic [15:0] w, h;
      logic        e_trig, e_busy;
      int          e_ev, e_miss;
   } vec_t;
   vec_t        q[$];
   logic        crst = 1'b1, cen = 1'b1, cret = 1'b0, cgate = 1'b0, clvl = 1'b0;
   logic [15:0] cw = 16'd4, ch = 16'd0;
   function automatic void add(string nm, logic tk, logic cl, logic et, logic eb, int ee, int em);
      vec_t v;
      v.name = nm; v.rstn = crst; v.en = cen; v.tick = tk; v.lvl = clvl;
      v.retrig = cret; v.gate = cgate; v.clr = cl; v.w = cw; v.h = ch;
      v.e_trig = et; v.e_busy = eb; v.e_ev = ee; v.e_miss = em;
      q.push_back(v);
   endfunction
   function automatic void chk(string nm, logic [15:0] act, logic [15:0] exp);
      checks++;
      if (act !== exp) $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      else passed++;
   endfunction
   int m_st, m_cnt, m_ev, m_miss;
   logic m_trig, m_busy;
   function automatic void model_step();
      int ns, nc, wl;
      logic ei, mi;
      ns = m_st; nc = m_cnt; ei = 1'b0; mi = 1'b0;
      wl = (width_i == 0) ? 1 : int'(width_i);
      if (!rstn) begin
         m_st = 0; m_cnt = 0; m_ev = 0; m_miss = 0; m_trig = 1'b0; m_busy = 1'b0;
         return;
      end
      if (!enable_i) begin
         ns = 0; nc = 0;
      end else if (m_st == 0) begin
         if (db_tick_i) begin ns = 1; nc = wl - 1; ei = 1'b1; end
      end else if (m_st == 1) begin
         if (db_tick_i && retrig_i) begin nc = wl - 1; ei = 1'b1; end
         else begin
            mi = db_tick_i;
            if (m_cnt != 0) nc = m_cnt - 1;
            else if (!(gate_i && db_level_i)) begin
               if (holdoff_i != 0) begin ns = 2; nc = int'(holdoff_i) - 1; end
               else ns = 0;
            end
         end
      end else begin
         mi = db_tick_i;
         if (m_cnt != 0) nc = m_cnt - 1; else ns = 0;
      end
      m_ev   = clear_i ? 0 : (ei && m_ev < 15) ? m_ev + 1 : m_ev;
      m_miss = clear_i ? 0 : (mi && m_miss < 15) ? m_miss + 1 : m_miss;
      m_st = ns; m_cnt = nc; m_trig = (ns == 1); m_busy = (ns != 0);
   endfunction
   initial begin
      rstn = 1'b0; db_level_i = 1'b0; db_tick_i = 1'b0; enable_i = 1'b1;
      retrig_i = 1'b0; gate_i = 1'b0; clear_i = 1'b0; width_i = 16'd4; holdoff_i = 16'd0;
      crst = 1'b0;
      add("reset", 0, 0, 0, 0, 0, 0);
      add("reset", 0, 0, 0, 0, 0, 0);
      crst = 1'b1;
      add("idle", 0, 0, 0, 0, 0, 0);
      add("t1_tick", 1, 0, 1, 1, 1, 0);
      repeat (3) add("t1_win", 0, 0, 1, 1, 1, 0);
      add("t1_end", 0, 0, 0, 0, 1, 0);
      cw = 16'd0;
      add("w0_tick", 1, 0, 1, 1, 2, 0);
      add("w0_end", 0, 0, 0, 0, 2, 0);
      add("clr", 0, 1, 0, 0, 0, 0);
      cw = 16'd3; ch = 16'd5;
      add("t2_tick", 1, 0, 1, 1, 1, 0);
      cw = 16'd9;
      add("t2_win", 0, 0, 1, 1, 1, 0);
      add("t2_miss_a", 1, 0, 1, 1, 1, 1);
      cw = 16'd3;
      repeat (3) add("t2_hold", 0, 0, 0, 1, 1, 1);
      add("t2_miss_h", 1, 0, 0, 1, 1, 2);
      add("t2_hold", 0, 0, 0, 1, 1, 2);
      add("t2_idle", 0, 0, 0, 0, 1, 2);
      add("t2_tick2", 1, 0, 1, 1, 2, 2);
      repeat (2) add("t2_win2", 0, 0, 1, 1, 2, 2);
      repeat (5) add("t2_hold2", 0, 0, 0, 1, 2, 2);
      add("t2_idle2", 0, 0, 0, 0, 2, 2);
      add("clr", 0, 1, 0, 0, 0, 0);
      cret = 1'b1; cw = 16'd4; ch = 16'd0;
      add("t3_tick", 1, 0, 1, 1, 1, 0);
      add("t3_win", 0, 0, 1, 1, 1, 0);
      add("t3_retrig", 1, 0, 1, 1, 2, 0);
      repeat (3) add("t3_win", 0, 0, 1, 1, 2, 0);
      add("t3_end", 0, 0, 0, 0, 2, 0);
      clvl = 1'b1;
      add("lvl_only", 0, 0, 0, 0, 2, 0);
      cgate = 1'b1;
      add("gate_tick", 1, 0, 1, 1, 3, 0);
      repeat (8) add("gate_hold", 0, 0, 1, 1, 3, 0);
      clvl = 1'b0;
      add("gate_drop", 0, 0, 0, 0, 3, 0);
      cgate = 1'b0; cret = 1'b0;
      add("clr", 0, 1, 0, 0, 0, 0);
      add("t4_tick", 1, 0, 1, 1, 1, 0);
      add("t4_win", 0, 0, 1, 1, 1, 0);
      cen = 1'b0;
      add("en_drop", 0, 0, 0, 0, 1, 0);
      add("en_tick", 1, 0, 0, 0, 1, 0);
      cen = 1'b1;
      add("en_back", 0, 0, 0, 0, 1, 0);
      add("clr", 0, 1, 0, 0, 0, 0);
      cw = 16'd0;
      for (int i = 1; i <= 17; i++) begin
         add("sat_ev", 1, 0, 1, 1, (i > 15) ? 15 : i, 0);
         add("sat_gap", 0, 0, 0, 0, (i > 15) ? 15 : i, 0);
      end
      add("clr_tick", 1, 1, 1, 1, 0, 0);
      add("clr_after", 0, 0, 0, 0, 0, 0);
      cw = 16'd40;
      add("miss_tick", 1, 0, 1, 1, 1, 0);
      for (int i = 1; i <= 18; i++) add("sat_miss", 1, 0, 1, 1, 1, (i > 15) ? 15 : i);
      cen = 1'b0;
      add("abort", 0, 0, 0, 0, 1, 15);
      cen = 1'b1; cw = 16'd4;
      add("clr", 0, 1, 0, 0, 0, 0);
      add("t6_tick", 1, 0, 1, 1, 1, 0);
      add("t6_win", 0, 0, 1, 1, 1, 0);
      crst = 1'b0;
      add("rst_mid", 1, 0, 0, 0, 0, 0);
      crst = 1'b1;
      add("post_rst", 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      foreach (q[i]) begin
         rstn = q[i].rstn; enable_i = q[i].en; db_tick_i = q[i].tick; db_level_i = q[i].lvl;
         retrig_i = q[i].retrig; gate_i = q[i].gate; clear_i = q[i].clr;
         width_i = q[i].w; holdoff_i = q[i].h;
         @(posedge clk);
         @(negedge clk);
         chk({q[i].name, "_trig"}, 16'(trig_o), 16'(q[i].e_trig));
         chk({q[i].name, "_busy"}, 16'(busy_o), 16'(q[i].e_busy));
         chk({q[i].name, "_ev"}, 16'(event_cnt_o), 16'(q[i].e_ev));
         chk({q[i].name, "_miss"}, 16'(missed_cnt_o), 16'(q[i].e_miss));
      end
      m_st = 0; m_cnt = 0; m_ev = 0; m_miss = 0; m_trig = 1'b0; m_busy = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         rstn       = ($urandom_range(99) != 0);
         enable_i   = ($urandom_range(19) != 0);
         db_tick_i  = ($urandom_range(3) == 0);
         db_level_i = ($urandom_range(1) == 0);
         retrig_i   = ($urandom_range(2) == 0);
         gate_i     = ($urandom_range(2) == 0);
         clear_i    = ($urandom_range(39) == 0);
         width_i    = 16'($urandom_range(6));
         holdoff_i  = 16'($urandom_range(4));
         model_step();
         @(posedge clk);
         @(negedge clk);
         chk("soak_trig", 16'(trig_o), 16'(m_trig));
         chk("soak_busy", 16'(busy_o), 16'(m_busy));
         chk("soak_ev", 16'(event_cnt_o), 16'(m_ev));
         chk("soak_miss", 16'(missed_cnt_o), 16'(m_miss));
      end
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
